multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: Multicycle_Control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of consecutive stalled memory cycles tolerated before error.
REQ-002 SHALL have ports (clock and reset first):
- clk_i, in, 1: sole clock; all state updates on its rising edge.
- rst_i, in, 1: reset, asynchronous and active-low.
- start_i, in, 1: run enable.
- instr_i, in, 32: instruction register contents from the datapath.
- zero_i, in, 1: ALU zero flag.
- mem_ready_i, in, 1: memory access completes this cycle.
- pc_write_o, out, 1: PC load enable.
- pc_src_o, out, 1: 0 = PC+4, 1 = branch target.
- ir_write_o, out, 1: IR load enable.
- imm_sel_o, out, 3: immediate format select (0 I, 1 S, 2 B, 3 shamt).
- alu_src_b_o, out, 1: 0 = rs2, 1 = immediate.
- alu_op_o, out, 4: ALU operation (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 MUL).
- mem_req_o, out, 1: memory request.
- mem_we_o, out, 1: memory write.
- iord_o, out, 1: memory address select (0 = PC, 1 = ALU result).
- reg_write_o, out, 1: register file write enable.
- wb_sel_o, out, 1: write-back source (0 = ALU, 1 = memory).
- busy_o, out, 1: high in every state except IDLE.
- err_o, out, 1: sticky error flag.
- state_o, out, 4: current state encoding.

Function
REQ-003 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, ALU_WB=9, BRANCH=10, HALT=11.
REQ-004 SHALL hold state in a register and decode outputs combinationally from the state and instr_i; an output not named as active in a state SHALL be 0.
REQ-005 IDLE: SHALL go to FETCH when start_i=1, else SHALL remain in IDLE.
REQ-006 FETCH: SHALL assert mem_req_o=1 with iord_o=0.
- When mem_ready_i=1: SHALL assert ir_write_o=1 and pc_write_o=1 with pc_src_o=0, then go to DECODE.
- Otherwise: SHALL stay in FETCH.
REQ-007 DECODE: SHALL branch on opcode instr_i[6:0]:
- 0110011 -> EXEC_R.
- 0010011 -> EXEC_I.
- 0000011 or 0100011 -> MEM_ADDR.
- 1100011 with funct3=000 -> BRANCH.
- Any other opcode -> HALT with err_o set.
REQ-008 EXEC_R: SHALL set alu_src_b_o=0 and select alu_op_o from {funct7, funct3}:
- 0000000/000 -> ADD; 0100000/000 -> SUB.
- 0000000/111 -> AND; 0000000/110 -> OR; 0000000/100 -> XOR; 0000000/001 -> SLL.
- 0000001/000 -> MUL.
- Any other combination -> HALT with err_o set.
REQ-009 EXEC_I: SHALL set alu_src_b_o=1.
- funct3=000 -> ADD with imm_sel_o=0.
- funct3=101 and funct7=0100000 -> SRA with imm_sel_o=3.
- Any other combination -> HALT with err_o set.
REQ-010 After EXEC_R or EXEC_I, SHALL go to ALU_WB, which asserts reg_write_o=1 with wb_sel_o=0 for exactly one cycle.
REQ-011 MEM_ADDR: SHALL set alu_op_o=ADD and alu_src_b_o=1, with imm_sel_o=0 for a load or imm_sel_o=1 for a store; then SHALL go to MEM_RD for a load or MEM_WR for a store.
REQ-012 MEM_RD: SHALL assert mem_req_o=1 and iord_o=1, and SHALL go to MEM_WB when mem_ready_i=1.
REQ-013 MEM_WB: SHALL assert reg_write_o=1 with wb_sel_o=1.
REQ-014 MEM_WR: SHALL assert mem_req_o=1, mem_we_o=1 and iord_o=1 until mem_ready_i=1.
REQ-015 BRANCH: SHALL set alu_op_o=SUB, alu_src_b_o=0 and imm_sel_o=2; when zero_i=1 SHALL assert pc_write_o=1 with pc_src_o=1.
REQ-016 End of instruction (after ALU_WB, MEM_WB, MEM_WR completion or BRANCH): SHALL go to FETCH if start_i=1, else to IDLE.
REQ-017 Latency with zero memory wait SHALL be: R/I-type 4 cycles, load 5, store 4, branch 3.
REQ-018 Wait counter:
- SHALL increment each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i=0.
- SHALL clear on every state change.
- On the cycle the count equals MAX_WAIT while mem_ready_i=0, SHALL go to HALT and set err_o.
- mem_ready_i=1 arriving on that same cycle SHALL take priority, so the access completes normally.
REQ-019 HALT: SHALL keep all enables at 0, SHALL hold err_o=1, and SHALL exit only via reset.
REQ-020 start_i deasserting mid-instruction SHALL NOT abort the instruction; it SHALL take effect only at the REQ-016 boundary.

Reset
REQ-021 rst_i=0 SHALL immediately, without a clock edge, force state IDLE, wait counter 0, err_o=0, and all outputs 0, including mid-instruction and mid-stall.
REQ-022 On the first rising clk_i after rst_i returns to 1, SHALL evaluate start_i per REQ-005.

Verification
REQ-023 instr_i=0x002081B3 (add x3,x1,x2), mem_ready_i=1, start_i=1 -> states 1,2,3,9; alu_op_o=0; reg_write_o=1 only in cycle 4.
REQ-024 instr_i=0x0040A183 (lw), mem_ready_i low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB has wb_sel_o=1 and reg_write_o=1; err_o=0.
REQ-025 instr_i=0x00208463 (beq): zero_i=1 -> pc_write_o=1 and pc_src_o=1 in BRANCH; zero_i=0 -> pc_write_o=0 there; both cases return to FETCH.
REQ-026 FETCH with mem_ready_i held 0 -> HALT after MAX_WAIT=15 stalled cycles; err_o=1; start_i toggling has no effect; rst_i=0 clears err_o.
REQ-027 instr_i=0x4020D193 (srai) -> imm_sel_o=3, alu_op_o=6; instr_i=0x0000007F -> HALT with err_o=1 on the cycle after DECODE.
REQ-028 rst_i pulsed low asynchronously during MEM_WR -> mem_req_o and mem_we_o drop to 0 before the next clock edge; state_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back for a small RV32 subset,
// with a bounded memory-stall watchdog that drops into a sticky HALT state.
module multicycle_control #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        ir_write_o,
  output logic [2:0]  imm_sel_o,
  output logic        alu_src_b_o,
  output logic [3:0]  alu_op_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        reg_write_o,
  output logic        wb_sel_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [3:0]  state_o
);
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
    S_MEM_WR = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRA = 4'd6, ALU_MUL = 4'd7;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             err;
  logic             stalled;
  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic             r_ok;
  logic [3:0]       r_op;
  logic             unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign funct7       = instr_i[31:25];
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_ADD;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: r_op = ALU_ADD;
      {7'b0100000, 3'b000}: r_op = ALU_SUB;
      {7'b0000000, 3'b111}: r_op = ALU_AND;
      {7'b0000000, 3'b110}: r_op = ALU_OR;
      {7'b0000000, 3'b100}: r_op = ALU_XOR;
      {7'b0000000, 3'b001}: r_op = ALU_SLL;
      {7'b0000001, 3'b000}: r_op = ALU_MUL;
      default:              r_ok = 1'b0;
    endcase
  end

  // Next-state and output decode; instruction end returns to FETCH or IDLE depending on start_i.
  always_comb begin
    next_state  = state;
    stalled     = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    ir_write_o  = 1'b0;
    imm_sel_o   = 3'd0;
    alu_src_b_o = 1'b0;
    alu_op_o    = ALU_ADD;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    reg_write_o = 1'b0;
    wb_sel_o    = 1'b0;
    case (state)
      S_IDLE: if (start_i) next_state = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          next_state = S_DECODE;
        end else begin
          stalled = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
          OP_BRANCH:         next_state = (funct3 == 3'b000) ? S_BRANCH : S_HALT;
          default:           next_state = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        if (r_ok) begin
          alu_op_o   = r_op;
          next_state = S_ALU_WB;
        end else begin
          next_state = S_HALT;
        end
      end
      S_EXEC_I: begin
        alu_src_b_o = 1'b1;
        if (funct3 == 3'b000) begin
          next_state = S_ALU_WB;
        end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
          alu_op_o   = ALU_SRA;
          imm_sel_o  = 3'd3;
          next_state = S_ALU_WB;
        end else begin
          next_state = S_HALT;
        end
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        next_state  = start_i ? S_FETCH : S_IDLE;
      end
      S_MEM_ADDR: begin
        alu_src_b_o = 1'b1;
        imm_sel_o   = (opcode == OP_LOAD) ? 3'd0 : 3'd1;
        next_state  = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) next_state = S_MEM_WB;
        else             stalled    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 1'b1;
        next_state  = start_i ? S_FETCH : S_IDLE;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) next_state = start_i ? S_FETCH : S_IDLE;
        else             stalled    = 1'b1;
      end
      S_BRANCH: begin
        alu_op_o   = ALU_SUB;
        imm_sel_o  = 3'd2;
        pc_write_o = zero_i;
        pc_src_o   = zero_i;
        next_state = start_i ? S_FETCH : S_IDLE;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
    // A ready on the limit cycle never reaches here, so completion wins over the watchdog.
    if (stalled && wait_cnt == WAIT_LIMIT) next_state = S_HALT;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= '0;
      else if (stalled)        wait_cnt <= wait_cnt + CNT_W'(1);
      if (next_state == S_HALT) err <= 1'b1;
    end
  end

  assign busy_o  = (state != S_IDLE);
  assign err_o   = err;
  assign state_o = state;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model plans the expected
// cycle-by-cycle behaviour, the driver replays it, and a negedge monitor compares.
module tb_multicycle_control;
  localparam int MAX_WAIT = 15;
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3, EXEC_I = 4'd4,
                         MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7, MEM_WR = 4'd8,
                         ALU_WB = 4'd9, BRANCH = 4'd10, HALT = 4'd11;

  logic        clk = 1'b0;
  logic        rst_n, start, zero, mem_ready;
  logic [31:0] instr;
  logic        pc_write, pc_src, ir_write, alu_src_b, mem_req, mem_we, iord, reg_write, wb_sel;
  logic        busy, err;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_op, state;

  multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .instr_i(instr), .zero_i(zero),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .pc_src_o(pc_src), .ir_write_o(ir_write),
    .imm_sel_o(imm_sel), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .iord_o(iord), .reg_write_o(reg_write), .wb_sel_o(wb_sel),
    .busy_o(busy), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_src, ir_write;
    logic [2:0] imm_sel;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       mem_req, mem_we, iord, reg_write, wb_sel, busy, err;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic        rdy, zr, st;
    obs_t        exp;
  } cyc_t;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
  } rent_t;

  rent_t r_tab [7] = '{'{7'h00, 3'd0, 4'd0}, '{7'h20, 3'd0, 4'd1}, '{7'h00, 3'd7, 4'd2},
                       '{7'h00, 3'd6, 4'd3}, '{7'h00, 3'd4, 4'd4}, '{7'h00, 3'd1, 4'd5},
                       '{7'h01, 3'd0, 4'd7}};

  obs_t  sb_q [$];
  cyc_t  plan [$];
  int    errors = 0;
  int    checks = 0;
  int    mon_cyc = 0;
  bit    in_idle;
  obs_t  mon_e, mon_a;

  function automatic obs_t current();
    obs_t r;
    r = '{pc_write: pc_write, pc_src: pc_src, ir_write: ir_write, imm_sel: imm_sel,
          alu_src_b: alu_src_b, alu_op: alu_op, mem_req: mem_req, mem_we: mem_we, iord: iord,
          reg_write: reg_write, wb_sel: wb_sel, busy: busy, err: err, state: state};
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = current();
      mon_cyc++;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle%0d exp_state=%0d: got %h (state %0d), want %h",
                 mon_cyc, mon_e.state, mon_a, mon_a.state, mon_e);
      end
    end
  end

  task automatic chk(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Idle state shows nothing; every other state is busy; err is only ever seen in HALT.
  function automatic obs_t base(input logic [3:0] st);
    obs_t r;
    r = '0;
    r.state = st;
    r.busy  = (st != IDLE);
    r.err   = (st == HALT);
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // kind: 0 illegal opcode, 1 R, 2 I, 3 load, 4 store, 5 beq
  function automatic void classify(input logic [31:0] ins, output int kind,
                                   output logic [3:0] op, output logic [2:0] imm, output bit ok);
    kind = 0; op = 4'd0; imm = 3'd0; ok = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        kind = 1;
        foreach (r_tab[i])
          if (r_tab[i].f7 == ins[31:25] && r_tab[i].f3 == ins[14:12]) begin
            ok = 1'b1;
            op = r_tab[i].op;
          end
      end
      7'b0010011: begin
        kind = 2;
        if (ins[14:12] == 3'd0) ok = 1'b1;
        else if (ins[14:12] == 3'd5 && ins[31:25] == 7'h20) begin
          ok = 1'b1; op = 4'd6; imm = 3'd3;
        end
      end
      7'b0000011: kind = 3;
      7'b0100011: kind = 4;
      7'b1100011: kind = (ins[14:12] == 3'd0) ? 5 : 0;
      default:    kind = 0;
    endcase
  endfunction

  task automatic add(input logic [31:0] ins, input obs_t e, input logic rdy, input logic zr,
                     input logic st);
    plan.push_back('{ins: ins, rdy: rdy, zr: zr, st: st, exp: e});
  endtask

  // Memory phase: stalled cycle k carries count k; a stall while the count equals MAX_WAIT halts.
  task automatic mem_phase(input logic [31:0] ins, input logic [3:0] st, input int stalls,
                           input logic end_st, output bit halted);
    obs_t x;
    x = base(st);
    x.mem_req = 1'b1;
    x.iord    = (st != FETCH);
    x.mem_we  = (st == MEM_WR);
    halted = 1'b0;
    for (int k = 0; k < stalls; k++) begin
      add(ins, x, 1'b0, rb(), rb());
      if (k == MAX_WAIT) begin
        halted = 1'b1;
        return;
      end
    end
    if (st == FETCH) begin
      x.ir_write = 1'b1;
      x.pc_write = 1'b1;
    end
    add(ins, x, 1'b1, rb(), (st == MEM_WR) ? end_st : rb());
  endtask

  task automatic plan_instr(input logic [31:0] ins, input int fst, input int mst,
                            input logic zr, input logic end_st, output bit halted);
    obs_t x;
    int kind;
    logic [3:0] op;
    logic [2:0] imm;
    bit ok;
    classify(ins, kind, op, imm, ok);
    if (in_idle) add(ins, base(IDLE), rb(), rb(), 1'b1);
    mem_phase(ins, FETCH, fst, 1'b0, halted);
    if (!halted) begin
      add(ins, base(DECODE), rb(), rb(), rb());
      case (kind)
        1, 2: begin
          x = base(kind == 1 ? EXEC_R : EXEC_I);
          x.alu_src_b = (kind == 2);
          if (ok) begin
            x.alu_op = op;
            x.imm_sel = imm;
          end
          add(ins, x, rb(), rb(), rb());
          if (ok) begin
            x = base(ALU_WB);
            x.reg_write = 1'b1;
            add(ins, x, rb(), rb(), end_st);
          end else begin
            halted = 1'b1;
          end
        end
        3, 4: begin
          x = base(MEM_ADDR);
          x.alu_src_b = 1'b1;
          x.imm_sel = (kind == 3) ? 3'd0 : 3'd1;
          add(ins, x, rb(), rb(), rb());
          mem_phase(ins, kind == 3 ? MEM_RD : MEM_WR, mst, end_st, halted);
          if (!halted && kind == 3) begin
            x = base(MEM_WB);
            x.reg_write = 1'b1;
            x.wb_sel = 1'b1;
            add(ins, x, rb(), rb(), end_st);
          end
        end
        5: begin
          x = base(BRANCH);
          x.alu_op = 4'd1;
          x.imm_sel = 3'd2;
          x.pc_write = zr;
          x.pc_src = zr;
          add(ins, x, rb(), zr, end_st);
        end
        default: halted = 1'b1;
      endcase
    end
    if (halted)
      for (int i = 0; i < 3; i++) add(ins, base(HALT), rb(), rb(), rb());
    in_idle = !halted && !end_st;
  endtask

  task automatic play();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      instr = c.ins;
      mem_ready = c.rdy;
      zero = c.zr;
      start = c.st;
      sb_q.push_back(c.exp);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk(name, current(), base(IDLE));
    #1;
    rst_n = 1'b1;
    in_idle = 1'b1;
  endtask

  task automatic run(input logic [31:0] ins, input int fst, input int mst, input logic zr,
                     input logic end_st);
    bit h;
    plan_instr(ins, fst, mst, zr, end_st, h);
    play();
    if (h) do_reset("rst_after_halt");
  endtask

  logic [31:0] pool [14] = '{32'h002081B3, 32'h402081B3, 32'h022081B3, 32'h0020F1B3,
                             32'h0020E1B3, 32'h0020C1B3, 32'h002091B3, 32'h0020A1B3,
                             32'h00508093, 32'h4020D193, 32'h0040A183, 32'h0020A223,
                             32'h00208463, 32'h00209463};

  initial begin
    bit h;
    rst_n = 1'b0; start = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", current(), base(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    in_idle = 1'b1;

    run(32'h002081B3, 0, 0, 1'b0, 1'b1);   // add
    run(32'h0040A183, 0, 3, 1'b0, 1'b1);   // lw with 3 wait cycles
    run(32'h00208463, 0, 0, 1'b1, 1'b1);   // beq taken
    run(32'h00208463, 0, 0, 1'b0, 1'b0);   // beq not taken, then idle
    run(32'h4020D193, 0, 0, 1'b0, 1'b1);   // srai
    run(32'h402081B3, 1, 0, 1'b0, 1'b1);   // sub
    run(32'h022081B3, 0, 0, 1'b0, 1'b1);   // mul
    run(32'h0020F1B3, 0, 0, 1'b0, 1'b1);   // and
    run(32'h0020E1B3, 0, 0, 1'b0, 1'b1);   // or
    run(32'h0020C1B3, 0, 0, 1'b0, 1'b1);   // xor
    run(32'h002091B3, 0, 0, 1'b0, 1'b0);   // sll
    run(32'h0020A223, 2, 2, 1'b0, 1'b1);   // sw
    run(32'h00508093, 0, 0, 1'b0, 1'b1);   // addi
    run(32'h002081B3, MAX_WAIT, 0, 1'b0, 1'b1);   // ready on the limit cycle completes
    run(32'h0040A183, 0, MAX_WAIT, 1'b0, 1'b1);
    run(32'h0000007F, 0, 0, 1'b0, 1'b1);   // illegal opcode
    run(32'h0020A1B3, 0, 0, 1'b0, 1'b1);   // illegal R funct
    run(32'h00007013, 0, 0, 1'b0, 1'b1);   // illegal I funct3
    run(32'h00209463, 0, 0, 1'b0, 1'b1);   // bne unsupported
    run(32'h002081B3, MAX_WAIT + 1, 0, 1'b0, 1'b1);  // fetch watchdog
    run(32'h0020A223, 0, MAX_WAIT + 1, 1'b0, 1'b1);  // store watchdog

    // Reset pulse in the middle of a stalled store.
    plan_instr(32'h0020A223, 0, 10, 1'b0, 1'b1, h);
    while (plan.size() > 7) void'(plan.pop_back());
    play();
    @(negedge clk);
    #1;
    chk_bit("memwr_req_before_rst", mem_req, 1'b1);
    chk_bit("memwr_we_before_rst", mem_we, 1'b1);
    do_reset("rst_mid_memwr");

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      int fst, mst;
      ins = ($urandom_range(0, 7) == 0) ? $urandom() : pool[$urandom_range(0, 13)];
      fst = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
      mst = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
      run(ins, fst, mst, rb(), $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
